// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: opcode field width, opcode encodings
// and the helper that pulls the opcode out of an instruction word.
package branch_pkg;

  localparam int unsigned OPW        = 5;
  // Widest instruction word the opcode helper accepts.
  localparam int unsigned MAX_DWIDTH = 64;

  typedef logic [OPW-1:0] opcode_t;

  localparam opcode_t JR   = OPW'(5'b01101);
  localparam opcode_t JPC  = OPW'(5'b01110);
  localparam opcode_t BRFL = OPW'(5'b01111);
  localparam opcode_t CALL = OPW'(5'b10000);
  localparam opcode_t RET  = OPW'(5'b10001);

  // Returns word[dwidth-1 -: OPW]. The caller zero-extends its word to MAX_DWIDTH.
  function automatic opcode_t get_opcode(input logic [MAX_DWIDTH-1:0] word,
                                         input int unsigned          dwidth);
    logic [MAX_DWIDTH-1:0] shifted;
    shifted = word >> (dwidth - OPW);
    return shifted[OPW-1:0];
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: storage, stack pointer and registered occupancy.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, pop       stack operations (push takes priority if both are set)
//   wdata           address to push
//   top_c           combinational top-of-stack, mem[sp-1]
//   count           occupancy, 0..DEPTH
//   full, empty     registered occupancy flags
// Build option: BRANCH_UNIT_RAS_WRAP_EN makes the stack circular, so a push
// on full overwrites the oldest entry instead of being dropped.
module ras_stack #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           top_c,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

`ifdef BRANCH_UNIT_RAS_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so sp wraps naturally at PW bits.
  always_comb begin
    do_push = push && (WRAP_EN || !full);
    do_pop  = pop && !push && !empty;
    top_c   = mem[sp - PW'(1)];
  end

  // Pointer and occupancy; count saturates at DEPTH when wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (do_push) begin
      sp    <= sp + PW'(1);
      empty <= 1'b0;
      if (!full) begin
        count <= count + CW'(1);
        full  <= (count == CW'(DEPTH - 1));
      end
    end else if (do_pop) begin
      sp    <= sp - PW'(1);
      count <= count - CW'(1);
      full  <= 1'b0;
      empty <= (count == CW'(1));
    end
  end

  // Storage is not reset; a write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      mem[sp] <= wdata;
    end
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch-target unit with integrated return-address stack.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   instr_valid         instr/rd/immediate/branch_addr valid this cycle
//   instr               instruction word; opcode in the top OPW bits
//   rd, immediate       jump base and sign-extended offset
//   branch_addr         return address pushed by CALL
//   err_clr             clears sticky overflow/underflow
//   target, target_valid  registered branch target and one-cycle strobe
//   count, full, empty  RAS occupancy
//   overflow, underflow sticky RAS error flags
// Build option: BRANCH_UNIT_RAS_WRAP_EN selects a circular RAS (see ras_stack).
module branch_unit_ras
  import branch_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 15,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [DWIDTH-1:0]          instr,
  input  logic [DWIDTH-1:0]          rd,
  input  logic [DWIDTH-1:0]          immediate,
  input  logic [AWIDTH-1:0]          branch_addr,
  input  logic                       err_clr,
  output logic [DWIDTH-1:0]          target,
  output logic                       target_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  opcode_t           opcode;
  logic              push;
  logic              pop;
  logic [AWIDTH-1:0] ras_top;
  logic [DWIDTH-1:0] target_nxt;
  logic              target_valid_nxt;
  logic              overflow_nxt;
  logic              underflow_nxt;

  ras_stack #(
    .WIDTH (AWIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (branch_addr),
    .top_c (ras_top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Decode and next-value logic; a new error overrides err_clr in the same cycle.
  always_comb begin
    opcode           = get_opcode(MAX_DWIDTH'(instr), DWIDTH);
    push             = 1'b0;
    pop              = 1'b0;
    target_nxt       = target;
    target_valid_nxt = 1'b0;
    overflow_nxt     = overflow && !err_clr;
    underflow_nxt    = underflow && !err_clr;
    if (instr_valid) begin
      case (opcode)
        JR, BRFL: begin
          target_nxt       = rd;
          target_valid_nxt = 1'b1;
        end
        JPC: begin
          target_nxt       = immediate + rd + DWIDTH'(1);
          target_valid_nxt = 1'b1;
        end
        CALL: begin
          push             = 1'b1;
          target_nxt       = rd;
          target_valid_nxt = 1'b1;
          if (full) begin
            overflow_nxt = 1'b1;
          end
        end
        RET: begin
          target_valid_nxt = 1'b1;
          if (empty) begin
            target_nxt    = '0;
            underflow_nxt = 1'b1;
          end else begin
            target_nxt = DWIDTH'(ras_top);
            pop        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target       <= '0;
      target_valid <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      target       <= target_nxt;
      target_valid <= target_valid_nxt;
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed self-checking bench for branch_unit_ras (DWIDTH=32, AWIDTH=15, DEPTH=32).
module tb_branch_unit_ras;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JPC  = 5'b01110;
  localparam logic [4:0] OP_BRFL = 5'b01111;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] rd;
  logic [31:0] immediate;
  logic [14:0] branch_addr;
  logic        err_clr;
  logic [31:0] target;
  logic        target_valid;
  logic [5:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int vectors    = 0;
  int miscompares = 0;

  branch_unit_ras dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .rd           (rd),
    .immediate    (immediate),
    .branch_addr  (branch_addr),
    .err_clr      (err_clr),
    .target       (target),
    .target_valid (target_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [4:0] op, input logic [31:0] r,
                      input logic [31:0] imm, input logic [14:0] ba, input logic clr);
    instr_valid = v;
    instr       = {op, 27'h0};
    rd          = r;
    immediate   = imm;
    branch_addr = ba;
    err_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, OP_NOP, 32'h0, 32'h0, 15'h0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_first_ret;
  logic [31:0] exp_last_ret;

  initial begin
`ifdef BRANCH_UNIT_RAS_WRAP_EN
    exp_first_ret = 32'd33;
    exp_last_ret  = 32'd2;
`else
    exp_first_ret = 32'd32;
    exp_last_ret  = 32'd1;
`endif
    rst = 1'b0;
    idle();
    idle();
    check("rst_target", target, 32'h0);
    check("rst_tvalid", 32'(target_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_unf", 32'(underflow), 32'h0);
    rst = 1'b1;

    // JR then hold
    step(1'b1, OP_JR, 32'h100, 32'h0, 15'h0, 1'b0);
    check("jr_target", target, 32'h100);
    check("jr_tvalid", 32'(target_valid), 32'h1);
    idle();
    check("jr_hold_tvalid", 32'(target_valid), 32'h0);
    check("jr_hold_target", target, 32'h100);

    // JPC arithmetic incl. wrap and negative offset
    step(1'b1, OP_JPC, 32'hFFFF_FFFF, 32'h0, 15'h0, 1'b0);
    check("jpc_wrap", target, 32'h0);
    check("jpc_wrap_tv", 32'(target_valid), 32'h1);
    step(1'b1, OP_JPC, 32'h10, 32'hFFFF_FFFE, 15'h0, 1'b0);
    check("jpc_neg", target, 32'hF);
    step(1'b1, OP_BRFL, 32'h55, 32'h0, 15'h0, 1'b0);
    check("brfl_target", target, 32'h55);
    step(1'b1, OP_NOP, 32'h77, 32'h0, 15'h0, 1'b0);
    check("nop_tvalid", 32'(target_valid), 32'h0);
    check("nop_hold", target, 32'h55);
    step(1'b0, OP_JR, 32'h99, 32'h0, 15'h0, 1'b0);
    check("invalid_tvalid", 32'(target_valid), 32'h0);
    check("invalid_hold", target, 32'h55);

    // Nested CALL/RET
    step(1'b1, OP_CALL, 32'h200, 32'h0, 15'h5, 1'b0);
    check("call1_target", target, 32'h200);
    check("call1_count", 32'(count), 32'h1);
    check("call1_empty", 32'(empty), 32'h0);
    step(1'b1, OP_CALL, 32'h300, 32'h0, 15'h7, 1'b0);
    check("call2_count", 32'(count), 32'h2);
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    check("ret1_target", target, 32'h7);
    check("ret1_count", 32'(count), 32'h1);
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    check("ret2_target", target, 32'h5);
    check("ret2_tvalid", 32'(target_valid), 32'h1);
    check("ret2_count", 32'(count), 32'h0);
    check("ret2_empty", 32'(empty), 32'h1);

    // Underflow and sticky behaviour
    step(1'b1, OP_JR, 32'h123, 32'h0, 15'h0, 1'b0);
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    check("unf_target", target, 32'h0);
    check("unf_tvalid", 32'(target_valid), 32'h1);
    check("unf_flag", 32'(underflow), 32'h1);
    check("unf_count", 32'(count), 32'h0);
    idle();
    idle();
    check("unf_sticky", 32'(underflow), 32'h1);
    step(1'b0, OP_NOP, 32'h0, 32'h0, 15'h0, 1'b1);
    check("unf_clr", 32'(underflow), 32'h0);
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b1);
    check("unf_clr_race", 32'(underflow), 32'h1);
    step(1'b0, OP_NOP, 32'h0, 32'h0, 15'h0, 1'b1);
    check("unf_clr2", 32'(underflow), 32'h0);

    // DEPTH+1 calls
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, OP_CALL, 32'(i) + 32'h1000, 32'h0, 15'(i), 1'b0);
    end
    check("fill_count", 32'(count), 32'd32);
    check("fill_full", 32'(full), 32'h1);
    check("fill_ovf", 32'(overflow), 32'h0);
    step(1'b1, OP_CALL, 32'h2021, 32'h0, 15'd33, 1'b0);
    check("ovf_count", 32'(count), 32'd32);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_target", target, 32'h2021);
    check("ovf_tvalid", 32'(target_valid), 32'h1);
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    check("ovf_ret_first", target, exp_first_ret);
    check("ovf_ret_count", 32'(count), 32'd31);
    check("ovf_ret_full", 32'(full), 32'h0);
    for (int i = 2; i <= 32; i++) begin
      step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    end
    check("ovf_ret_last", target, exp_last_ret);
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_unf", 32'(underflow), 32'h0);
    step(1'b0, OP_NOP, 32'h0, 32'h0, 15'h0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);

    // Reset coinciding with a CALL
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    step(1'b1, OP_CALL, 32'h400, 32'h0, 15'h11, 1'b0);
    step(1'b1, OP_CALL, 32'h401, 32'h0, 15'h12, 1'b0);
    step(1'b1, OP_CALL, 32'h402, 32'h0, 15'h13, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b0;
    step(1'b1, OP_CALL, 32'h403, 32'h0, 15'h14, 1'b0);
    check("rstcall_count", 32'(count), 32'h0);
    check("rstcall_tvalid", 32'(target_valid), 32'h0);
    check("rstcall_target", target, 32'h0);
    check("rstcall_unf", 32'(underflow), 32'h0);
    check("rstcall_empty", 32'(empty), 32'h1);
    rst = 1'b1;
    step(1'b1, OP_RET, 32'h0, 32'h0, 15'h0, 1'b0);
    check("post_rst_ret", target, 32'h0);
    check("post_rst_unf", 32'(underflow), 32'h1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
Registered branch-target unit for the CPU with an integrated, parametrised return-address stack (RAS).
- Decodes the 5-bit opcode in the instruction's top bits for each valid instruction.
- Computes the absolute branch target and manages nested CALL/RET.
- Presents the target one cycle later with a valid strobe.
- Reports stack occupancy plus sticky overflow/underflow errors to the control unit.

Parameters:
- DWIDTH, 32: instruction/data width; width of target, rd and immediate.
- AWIDTH, 15: return-address width (instruction memory address).
- DEPTH, 32: RAS entries; power of two, at least 2.
- OPW, 5: opcode field width, taken from instr[DWIDTH-1:DWIDTH-OPW].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- instr_valid  in  1  instr, rd, immediate and branch_addr are valid this cycle.
- instr  in  DWIDTH  instruction word.
- rd  in  DWIDTH  register operand (jump base).
- immediate  in  DWIDTH  sign-extended offset.
- branch_addr  in  AWIDTH  return address to push on CALL.
- err_clr  in  1  clears the sticky error flags.
- target  out  DWIDTH  registered absolute branch target.
- target_valid  out  1  one-cycle strobe: target is valid.
- count  out  $clog2(DEPTH+1)  RAS occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: CALL found the stack full.
- underflow  out  1  sticky: RET found the stack empty.

Behaviour:
- Reset (rst==0 at posedge):
  - target=0, target_valid=0, count=0, overflow=0, underflow=0, so empty=1 and full=0.
  - Stack pointer = 0; storage contents are not reset.
  - Reset has priority over every other input.
- Latency: an instruction accepted at edge N drives target/target_valid during the cycle after edge N.
  - target_valid lasts exactly one cycle per branch instruction.
  - target holds its last value when target_valid=0.
- Accepting instructions: one per cycle whenever instr_valid=1; there is no stall or backpressure.
- Opcodes (when instr_valid=1):
  - JR 01101, BRFL 01111: target=rd, target_valid=1.
  - JPC 01110: target=immediate+rd+1, truncated modulo 2^DWIDTH; target_valid=1.
  - CALL 10000: push branch_addr, target=rd, target_valid=1.
  - RET 10001: target = zero-extended top-of-stack, then pop; target_valid=1.
  - Any other opcode, or instr_valid=0: no stack change, target_valid=0.
- Stack pointer: points to the next free slot; top-of-stack = mem[sp-1].
- Back-to-back ops: CALL at edge N followed by RET at edge N+1 returns the address pushed at N. No bypass is needed, because the write completes at edge N.
- CALL with full=1: see Optional Feature.
- RET with empty=1:
  - No pointer change; target=0, target_valid=1, underflow set.
- Sticky errors: overflow/underflow stay set until err_clr=1. If a new error and err_clr occur in the same cycle, the new error wins.
- count, full and empty are registered and update on the same edge as the push/pop.

Optional Feature:
Macro: BRANCH_UNIT_RAS_WRAP_EN
- Defined: the RAS is circular. CALL on full overwrites the oldest entry, sp wraps modulo DEPTH, count stays DEPTH, and overflow is still set (sticky) as a diagnostic. A later RET returns the most recent entries.
- Undefined: CALL on full drops the push (sp and count unchanged), sets overflow, and still issues target=rd with target_valid=1.

Decomposition:
- Package branch_pkg holds:
  - OPW and the opcode localparams JR, JPC, BRFL, CALL, RET.
  - A helper function extracting the opcode field from an instruction word.
- Sub-module ras_stack(WIDTH=AWIDTH, DEPTH): storage, pointer, count/full/empty, push/pop, and the wrap behaviour under the macro.
- The top level holds the decode, target arithmetic, output registers and sticky errors.

Test Plan:
- Reset then JR with rd=0x100: next cycle target=0x100, target_valid=1; the cycle after, target_valid=0 and target holds 0x100.
- JPC with rd=0xFFFFFFFF, imm=0: target=0x00000000 (wrap); imm=0xFFFFFFFE (-2), rd=0x10: target=0x0F.
- CALL branch_addr=0x0005 then 0x0007, then RET, RET: targets 0x7 then 0x5; count goes 1, 2, 1, 0; empty=1 at the end.
- RET on empty: target=0, underflow=1 held across idle cycles; err_clr pulse clears it; err_clr coinciding with a second empty RET leaves underflow=1.
- DEPTH+1 CALLs with addresses 1..33:
  - Without macro: count=32, overflow=1, and the first RET returns 32.
  - With macro: the first RET returns 33, and the 32nd RET returns 2.
- rst=0 asserted in the same cycle as a CALL when count=3: count=0, no push, target_valid=0, flags cleared.
